// File: rtl/uart_tx_queue.sv
// Byte FIFO plus send sequencer between the keyboard ASCII path and the UART
// transmitter: every queued byte yields exactly one txStart, paced by txBusy.
module uart_tx_queue #(
  parameter int DEPTH        = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pushValid,
  input  logic [DATA_WIDTH-1:0]   pushData,
  output logic                    pushReady,
  input  logic                    clearOverflow,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    txStart,
  output logic [DATA_WIDTH-1:0]   txData,
  input  logic                    txBusy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wrPtr;
  logic [AW-1:0]         r_rdPtr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_txStart;
  logic [DATA_WIDTH-1:0] r_txData;
  logic [TW-1:0]         r_timer;
  state_t                r_state;

  logic w_full;
  logic w_push;
  logic w_pop;

  // Fullness comes from the registered count only, so a pop in the same
  // cycle never frees room for a push that arrives while full.
  assign w_full = (r_count == FULL_COUNT);
  assign w_push = pushValid && !w_full;
  assign w_pop  = (r_state == S_START);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A dropped push takes priority over a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (pushValid && w_full) begin
      r_overflow <= 1'b1;
    end else if (clearOverflow) begin
      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_txStart <= 1'b0;
      r_txData  <= '0;
      r_timer   <= '0;
    end else begin
      r_txStart <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if ((r_count != '0) && !txBusy) begin
            r_state   <= S_START;
            r_txStart <= 1'b1;
            r_txData  <= r_mem[r_rdPtr];
          end
        end
        S_START: begin
          r_state <= S_WAIT_BUSY;
          r_timer <= '0;
        end
        // A transmitter that never raises busy is assumed to have taken the byte.
        S_WAIT_BUSY: begin
          if (txBusy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_timer == TIMER_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!txBusy) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pushReady = !w_full;
  assign overflow  = r_overflow;
  assign count     = r_count;
  assign txStart   = r_txStart;
  assign txData    = r_txData;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: directed scenarios plus randomized
// traffic, scored against a queue-based model and a simple transmitter model.
module tb_uart_tx_queue;

  localparam int DEPTH        = 16;
  localparam int DW           = 8;
  localparam int BUSY_TIMEOUT = 4;
  localparam int CW           = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          pushValid;
  logic [DW-1:0] pushData;
  logic          pushReady;
  logic          clearOverflow;
  logic          overflow;
  logic [CW-1:0] count;
  logic          txStart;
  logic [DW-1:0] txData;
  logic          txBusy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mq[$];
  int         mCount;
  logic       mOvf;
  logic [7:0] mLastData;

  bit   autoBusy;
  bit   randBusy;
  bit   extBusy;
  int   busyLen;
  int   busyLeft;
  logic prevBusy;

  int         cycNum;
  int         lastStartCyc;
  logic [7:0] sentLog[$];
  int         startCycLog[$];

  logic       obsStart;
  logic [7:0] obsData;
  int         obsCount;
  logic       obsReady;
  logic       obsOvf;

  uart_tx_queue #(
    .DEPTH(DEPTH),
    .DATA_WIDTH(DW),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pushValid(pushValid),
    .pushData(pushData),
    .pushReady(pushReady),
    .clearOverflow(clearOverflow),
    .overflow(overflow),
    .count(count),
    .txStart(txStart),
    .txData(txData),
    .txBusy(txBusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mCount    = 0;
    mOvf      = 1'b0;
    mLastData = 8'h00;
  endtask

  // One clock cycle: score this cycle's outputs, drive its inputs, then
  // advance the model to what the next edge should produce.
  task automatic cycle(input logic pv, input logic [7:0] pd, input logic clr);
    logic accept;
    @(negedge clk);
    cycNum++;
    obsStart = txStart;
    obsData  = txData;
    obsCount = int'(count);
    obsReady = pushReady;
    obsOvf   = overflow;
    check("count", 32'(count), 32'(mCount));
    check("overflow", 32'(overflow), 32'(mOvf));
    check("pushReady", 32'(pushReady), 32'(mCount < DEPTH));
    if (txStart) begin
      check("startNonEmpty", 32'(mCount > 0), 32'd1);
      check("startBusyLow", 32'(prevBusy), 32'd0);
      check("startSpacing", 32'((cycNum - lastStartCyc) >= 3), 32'd1);
      if (mq.size() > 0) begin
        check("txDataHead", 32'(txData), 32'(mq[0]));
        mLastData = mq.pop_front();
      end
      lastStartCyc = cycNum;
      sentLog.push_back(txData);
      startCycLog.push_back(cycNum);
    end else begin
      check("txDataHold", 32'(txData), 32'(mLastData));
    end
    pushValid     = pv;
    pushData      = pd;
    clearOverflow = clr;
    txBusy        = extBusy || (busyLeft > 0);
    if (busyLeft > 0) busyLeft--;
    if (txStart && autoBusy) busyLeft = randBusy ? int'($urandom_range(8, 0)) : busyLen;
    prevBusy = txBusy;
    accept = pv && (mCount < DEPTH);
    if (pv && (mCount == DEPTH)) mOvf = 1'b1;
    else if (clr) mOvf = 1'b0;
    mCount = mCount + (accept ? 1 : 0) - (txStart ? 1 : 0);
    if (accept) mq.push_back(pd);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((mq.size() != 0 || busyLeft != 0) && n < budget) begin
      cycle(1'b0, 8'h00, 1'b0);
      n++;
    end
    check(tag, 32'(mq.size()), 32'd0);
    repeat (BUSY_TIMEOUT + 6) cycle(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int base;
    int sbase;
    int peak;
    int n;
    logic [7:0] expSeq[$];

    rst = 1'b1;
    pushValid = 1'b0;
    pushData = 8'h00;
    clearOverflow = 1'b0;
    txBusy = 1'b0;
    autoBusy = 1'b0;
    randBusy = 1'b0;
    extBusy = 1'b0;
    busyLen = 0;
    busyLeft = 0;
    prevBusy = 1'b0;
    cycNum = 0;
    lastStartCyc = -100;
    modelReset();

    repeat (2) @(negedge clk);
    check("rst count", 32'(count), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst txStart", 32'(txStart), 32'd0);
    check("rst txData", 32'(txData), 32'd0);
    check("rst pushReady", 32'(pushReady), 32'd1);
    rst = 1'b0;

    $display("[TB] single byte with timeout");
    cycle(1'b1, 8'h41, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("t1 noEarlyStart", 32'(obsStart), 32'd0);
    cycle(1'b0, 8'h00, 1'b0);
    check("t1 start", 32'(obsStart), 32'd1);
    check("t1 data", 32'(obsData), 32'h41);
    cycle(1'b1, 8'h42, 1'b0);
    check("t1 waitBusy", 32'(obsStart), 32'd0);
    for (int i = 0; i < BUSY_TIMEOUT; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      check("t1 timeoutHold", 32'(obsStart), 32'd0);
    end
    cycle(1'b0, 8'h00, 1'b0);
    check("t1 restart", 32'(obsStart), 32'd1);
    check("t1 restartData", 32'(obsData), 32'h42);
    drain("t1 drain", 50);
    check("t1 countZero", 32'(obsCount), 32'd0);

    $display("[TB] three bytes with busy transmitter");
    autoBusy = 1'b1;
    busyLen = 10;
    base = sentLog.size();
    sbase = startCycLog.size();
    peak = 0;
    cycle(1'b1, 8'h68, 1'b0);
    cycle(1'b1, 8'h69, 1'b0);
    if (obsCount > peak) peak = obsCount;
    cycle(1'b1, 8'h0D, 1'b0);
    if (obsCount > peak) peak = obsCount;
    n = 0;
    while (sentLog.size() < base + 3 && n < 200) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (obsCount > peak) peak = obsCount;
      n++;
    end
    check("t2 starts", 32'(sentLog.size() - base), 32'd3);
    check("t2 peak", 32'(peak), 32'd2);
    if (sentLog.size() >= base + 3) begin
      check("t2 byte0", 32'(sentLog[base]), 32'h68);
      check("t2 byte1", 32'(sentLog[base+1]), 32'h69);
      check("t2 byte2", 32'(sentLog[base+2]), 32'h0D);
      check("t2 gap0", 32'(startCycLog[sbase+1] - startCycLog[sbase]), 32'd13);
      check("t2 gap1", 32'(startCycLog[sbase+2] - startCycLog[sbase+1]), 32'd13);
    end
    drain("t2 drain", 100);

    $display("[TB] fill while busy, overflow and clear");
    extBusy = 1'b1;
    base = sentLog.size();
    for (int i = 0; i <= DEPTH; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      if (i == DEPTH) begin
        check("t3 fullCount", 32'(obsCount), 32'(DEPTH));
        check("t3 fullReady", 32'(obsReady), 32'd0);
        check("t3 ovfNotYet", 32'(obsOvf), 32'd0);
      end
    end
    cycle(1'b0, 8'h00, 1'b0);
    check("t3 ovfSet", 32'(obsOvf), 32'd1);
    check("t3 countHeld", 32'(obsCount), 32'(DEPTH));
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("t6 ovfCleared", 32'(obsOvf), 32'd0);

    busyLen = 30;
    extBusy = 1'b0;
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0);
    check("t4 popCycle", 32'(obsStart), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    check("t4 count", 32'(obsCount), 32'(DEPTH - 1));
    check("t4 ovf", 32'(obsOvf), 32'd1);
    cycle(1'b1, 8'h20, 1'b0);
    check("t6 ovfClear2", 32'(obsOvf), 32'd0);
    cycle(1'b1, 8'h21, 1'b1);
    check("t6 refull", 32'(obsCount), 32'(DEPTH));
    cycle(1'b0, 8'h00, 1'b0);
    check("t6 setWins", 32'(obsOvf), 32'd1);
    busyLen = 2;
    drain("t3 drain", 1000);
    for (int i = 0; i < DEPTH; i++) expSeq.push_back(8'(i));
    expSeq.push_back(8'h20);
    check("t3 sentCount", 32'(sentLog.size() - base), 32'(expSeq.size()));
    if (sentLog.size() - base == expSeq.size()) begin
      for (int i = 0; i < expSeq.size(); i++) check("t3 sentOrder", 32'(sentLog[base+i]), 32'(expSeq[i]));
    end

    $display("[TB] async reset mid transfer");
    busyLen = 20;
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(48 + i), 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    check("t5 queued", 32'(obsCount), 32'd5);
    rst = 1'b1;
    pushValid = 1'b0;
    clearOverflow = 1'b0;
    #1;
    check("t5 count", 32'(count), 32'd0);
    check("t5 overflow", 32'(overflow), 32'd0);
    check("t5 txStart", 32'(txStart), 32'd0);
    check("t5 txData", 32'(txData), 32'd0);
    check("t5 pushReady", 32'(pushReady), 32'd1);
    modelReset();
    cycle(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    base = sentLog.size();
    repeat (40) cycle(1'b0, 8'h00, 1'b0);
    check("t5 noStart", 32'(sentLog.size() - base), 32'd0);

    $display("[TB] randomized traffic");
    randBusy = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(39, 0) == 0) extBusy = ~extBusy;
      cycle($urandom_range(2, 0) != 0, 8'($urandom), $urandom_range(19, 0) == 0);
    end
    extBusy = 1'b0;
    drain("rand drain", 3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
